// File: rtl/pixel_layer_fetch_pkg.sv
// Shared constants for the sprite fetch path: SRAM layout, object IDs and the
// fetch FSM encoding.
package sram_pkg;
    localparam int ADDR_WIDTH  = 16;
    localparam int COLOR_WIDTH = 8;
    localparam int MAX_OBJ     = 8;

    // Each layer owns a 4K-entry sprite region; W*H never exceeds 4096.
    localparam logic [ADDR_WIDTH-1:0] OBJ_BASE [MAX_OBJ] = '{
        16'h0000, 16'h1000, 16'h2000, 16'h3000,
        16'h4000, 16'h5000, 16'h6000, 16'h7000
    };
    localparam logic [10:0] OBJ_W [MAX_OBJ] = '{
        11'd32, 11'd32, 11'd32, 11'd32, 11'd16, 11'd48, 11'd64, 11'd8
    };
    localparam logic [10:0] OBJ_H [MAX_OBJ] = '{
        11'd32, 11'd16, 11'd32, 11'd24, 11'd16, 11'd32, 11'd64, 11'd8
    };
endpackage

package game_pkg;
    typedef enum logic [3:0] {
        OBJECT_MAP    = 4'd0,
        OBJECT_PLAYER = 4'd1,
        OBJECT_ENEMY  = 4'd2,
        OBJECT_BULLET = 4'd3,
        OBJECT_ITEM   = 4'd4,
        OBJECT_HUD    = 4'd5,
        OBJECT_CURSOR = 4'd6,
        OBJECT_FX     = 4'd7,
        OBJECT_BG     = 4'd8
    } ObjectID;

    localparam int MAX_LAYERS = 8;
    localparam ObjectID LAYER_ID [MAX_LAYERS] = '{
        OBJECT_CURSOR, OBJECT_HUD, OBJECT_PLAYER, OBJECT_BULLET,
        OBJECT_ENEMY, OBJECT_ITEM, OBJECT_FX, OBJECT_BG
    };
endpackage

package pixel_layer_fetch_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_READ,
        ST_WAIT,
        ST_OUT
    } fetch_state_t;

    // 11-bit compare so that origin+len cannot wrap past the 10-bit screen.
    function automatic logic in_span(input logic [9:0] p, input logic [9:0] o,
                                     input logic [10:0] len);
        return ({1'b0, p} >= {1'b0, o}) && ({1'b0, p} < ({1'b0, o} + len));
    endfunction
endpackage

// File: rtl/pixel_layer_fetch_enc.sv
// Combinational lowest-set-bit encoder over the remaining layer mask.
module layer_priority_enc #(
    parameter int NUM_OBJ = 8,
    parameter int IW      = 3
) (
    input  logic [NUM_OBJ-1:0] mask,
    output logic [IW-1:0]      idx,
    output logic               empty
);
    always_comb begin
        idx   = '0;
        empty = 1'b1;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx   = IW'(i);
                empty = 1'b0;
            end
        end
    end
endmodule

// File: rtl/pixel_layer_fetch.sv
// Per-pixel layer resolver: hit-tests all layers at accept, then walks them in
// priority order reading sprite SRAM until an opaque pixel is found.
module pixel_layer_fetch
    import sram_pkg::*;
    import game_pkg::*;
    import pixel_layer_fetch_pkg::*;
#(
    parameter int      NUM_OBJ     = 8,
    parameter ObjectID FALLBACK_ID = OBJECT_MAP
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_px_valid,
    output logic                            o_px_ready,
    input  logic [9:0]                      i_px_x,
    input  logic [9:0]                      i_px_y,
    input  logic [NUM_OBJ-1:0]              i_obj_en,
    input  logic [NUM_OBJ-1:0][9:0]         i_obj_x,
    input  logic [NUM_OBJ-1:0][9:0]         i_obj_y,
    output logic                            o_sram_rd,
    output logic [ADDR_WIDTH-1:0]           o_sram_addr,
    input  logic                            i_sram_rvalid,
    input  logic [COLOR_WIDTH-1:0]          i_sram_rdata,
    output logic                            o_valid,
    input  logic                            i_ready,
    output ObjectID                         o_object_id,
    output logic [COLOR_WIDTH-1:0]          o_encoded_color
);
    localparam int IW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

    fetch_state_t                          state;
    logic [NUM_OBJ-1:0]                    mask;
    logic [NUM_OBJ-1:0]                    hit;
    logic [NUM_OBJ-1:0]                    rest;
    logic [NUM_OBJ-1:0][ADDR_WIDTH-1:0]    off_c;
    logic [NUM_OBJ-1:0][ADDR_WIDTH-1:0]    lane_off;
    logic [IW-1:0]                         cur_k;
    logic [IW-1:0]                         enc_idx;
    logic                                  enc_empty;

    // Offsets are latched with the mask so later object moves cannot disturb
    // the pixel in flight.
    for (genvar k = 0; k < NUM_OBJ; k++) begin : g_lane
        logic [9:0] dx;
        logic [9:0] dy;
        assign dx       = i_px_x - i_obj_x[k];
        assign dy       = i_px_y - i_obj_y[k];
        assign hit[k]   = i_obj_en[k]
                        && in_span(i_px_x, i_obj_x[k], OBJ_W[k])
                        && in_span(i_px_y, i_obj_y[k], OBJ_H[k]);
        assign off_c[k] = ADDR_WIDTH'(dy) * ADDR_WIDTH'(OBJ_W[k]) + ADDR_WIDTH'(dx);
    end

    layer_priority_enc #(.NUM_OBJ(NUM_OBJ), .IW(IW)) u_enc (
        .mask  (mask),
        .idx   (enc_idx),
        .empty (enc_empty)
    );

    assign rest = mask & ~(NUM_OBJ'(1) << cur_k);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= ST_IDLE;
            mask            <= '0;
            lane_off        <= '0;
            cur_k           <= '0;
            o_px_ready      <= 1'b1;
            o_valid         <= 1'b0;
            o_sram_rd       <= 1'b0;
            o_sram_addr     <= '0;
            o_object_id     <= FALLBACK_ID;
            o_encoded_color <= '0;
        end else begin
            o_sram_rd <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_px_valid) begin
                        mask       <= hit;
                        lane_off   <= off_c;
                        o_px_ready <= 1'b0;
                        state      <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (enc_empty) begin
                        o_object_id     <= FALLBACK_ID;
                        o_encoded_color <= '0;
                        o_valid         <= 1'b1;
                        state           <= ST_OUT;
                    end else begin
                        cur_k       <= enc_idx;
                        o_sram_addr <= OBJ_BASE[enc_idx] + lane_off[enc_idx];
                        o_sram_rd   <= 1'b1;
                        state       <= ST_READ;
                    end
                end
                ST_READ: state <= ST_WAIT;
                ST_WAIT: begin
                    if (i_sram_rvalid) begin
                        // A transparent last layer still owns the pixel.
                        if ((|i_sram_rdata) || (rest == '0)) begin
                            o_object_id     <= LAYER_ID[cur_k];
                            o_encoded_color <= i_sram_rdata;
                            o_valid         <= 1'b1;
                            state           <= ST_OUT;
                        end else begin
                            mask  <= rest;
                            state <= ST_SCAN;
                        end
                    end
                end
                ST_OUT: begin
                    if (i_ready) begin
                        o_valid    <= 1'b0;
                        o_px_ready <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_layer_fetch.sv
// Directed and randomized bench for pixel_layer_fetch with an SRAM responder
// and a priority-walk reference model.
module tb_pixel_layer_fetch;
    import sram_pkg::*;
    import game_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   px_valid = 1'b0;
    logic                   px_ready;
    logic [9:0]             px_x = '0;
    logic [9:0]             px_y = '0;
    logic [7:0]             obj_en = '0;
    logic [7:0][9:0]        obj_x = '0;
    logic [7:0][9:0]        obj_y = '0;
    logic                   sram_rd;
    logic [15:0]            sram_addr;
    logic                   rvalid = 1'b0;
    logic [7:0]             rdata = '0;
    logic                   valid;
    logic                   ready = 1'b0;
    ObjectID                object_id;
    logic [7:0]             color;

    logic [7:0]             mem [65536];
    logic [15:0]            rd_q [$];
    logic [15:0]            exp_q [$];
    int                     exp_id;
    int                     exp_col;
    int                     sram_lat = 1;
    int                     cnt = 0;
    logic [15:0]            paddr = '0;
    int                     n_vec = 0;
    int                     n_err = 0;

    always #5 clk = ~clk;

    pixel_layer_fetch #(.NUM_OBJ(8), .FALLBACK_ID(OBJECT_MAP)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_px_valid      (px_valid),
        .o_px_ready      (px_ready),
        .i_px_x          (px_x),
        .i_px_y          (px_y),
        .i_obj_en        (obj_en),
        .i_obj_x         (obj_x),
        .i_obj_y         (obj_y),
        .o_sram_rd       (sram_rd),
        .o_sram_addr     (sram_addr),
        .i_sram_rvalid   (rvalid),
        .i_sram_rdata    (rdata),
        .o_valid         (valid),
        .i_ready         (ready),
        .o_object_id     (object_id),
        .o_encoded_color (color)
    );

    // SRAM model: data returns sram_lat cycles after the read strobe cycle.
    always @(posedge clk) begin
        rvalid <= 1'b0;
        if (sram_rd) begin
            rd_q.push_back(sram_addr);
            if (sram_lat <= 1) begin
                rvalid <= 1'b1;
                rdata  <= mem[sram_addr];
            end else begin
                cnt   <= sram_lat - 1;
                paddr <= sram_addr;
            end
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                rvalid <= 1'b1;
                rdata  <= mem[paddr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Walk layers in priority order; the first opaque hit wins, otherwise the
    // last hit with color 0, otherwise the fallback.
    task automatic model(input int x, input int y);
        int a;
        exp_q.delete();
        exp_id  = int'(OBJECT_MAP);
        exp_col = 0;
        for (int k = 0; k < 8; k++) begin
            if (obj_en[k] && x >= int'(obj_x[k]) && x < int'(obj_x[k]) + int'(OBJ_W[k])
                && y >= int'(obj_y[k]) && y < int'(obj_y[k]) + int'(OBJ_H[k])) begin
                a = int'(OBJ_BASE[k]) + (y - int'(obj_y[k])) * int'(OBJ_W[k]) + (x - int'(obj_x[k]));
                exp_q.push_back(a[15:0]);
                exp_id  = int'(LAYER_ID[k]);
                exp_col = int'(mem[a[15:0]]);
                if (mem[a[15:0]] != 8'd0) break;
            end
        end
    endtask

    task automatic clear_objs();
        obj_en = '0;
        obj_x  = '0;
        obj_y  = '0;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the
    // output handshake.
    task automatic run_px(input int x, input int y, input int lat, input int stall);
        int k;
        int n;
        int exp_edges;
        model(x, y);
        n         = exp_q.size();
        exp_edges = (n == 0) ? 1 : n * (lat + 2);
        chk("px_ready_idle", {31'd0, px_ready}, 32'd1);
        rd_q.delete();
        px_valid = 1'b1;
        px_x     = 10'(x);
        px_y     = 10'(y);
        sram_lat = lat;
        @(negedge clk);
        px_valid = 1'b0;
        obj_en   = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            obj_x[i] = 10'($urandom);
            obj_y[i] = 10'($urandom);
        end
        k = 0;
        while (!valid && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("result_timeout", {31'd0, k < 400}, 32'd1);
        chk("latency", k, exp_edges);
        chk("object_id", {28'd0, object_id}, exp_id);
        chk("color", {24'd0, color}, exp_col);
        for (int s = 0; s < stall; s++) begin
            px_valid = 1'b1;
            @(negedge clk);
            chk("bp_valid", {31'd0, valid}, 32'd1);
            chk("bp_id", {28'd0, object_id}, exp_id);
            chk("bp_color", {24'd0, color}, exp_col);
            chk("bp_px_ready", {31'd0, px_ready}, 32'd0);
        end
        px_valid = 1'b0;
        chk("n_reads", rd_q.size(), n);
        for (int i = 0; i < n && i < rd_q.size(); i++) chk("rd_addr", {16'd0, rd_q[i]}, {16'd0, exp_q[i]});
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("valid_dropped", {31'd0, valid}, 32'd0);
    endtask

    initial begin
        int x;
        int y;
        logic saw_valid;
        for (int i = 0; i < 65536; i++)
            mem[i] = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 255));

        @(negedge clk);
        @(negedge clk);
        chk("rst_px_ready", {31'd0, px_ready}, 32'd1);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_sram_rd", {31'd0, sram_rd}, 32'd0);
        chk("rst_sram_addr", {16'd0, sram_addr}, 32'd0);
        chk("rst_object_id", {28'd0, object_id}, int'(OBJECT_MAP));
        chk("rst_color", {24'd0, color}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single opaque layer
        clear_objs();
        obj_en[2] = 1'b1; obj_x[2] = 10'd100; obj_y[2] = 10'd50;
        mem[16'h2000 + 10 * 32 + 10] = 8'd5;
        run_px(110, 60, 1, 0);
        chk("t1_addr", {16'd0, rd_q[0]}, 32'h214A);
        chk("t1_id", exp_id, int'(OBJECT_PLAYER));

        // Transparent fall-through from layer 0 to layer 3
        clear_objs();
        obj_en[0] = 1'b1; obj_x[0] = 10'd200; obj_y[0] = 10'd100;
        obj_en[3] = 1'b1; obj_x[3] = 10'd200; obj_y[3] = 10'd100;
        mem[16'h0000 + 5 * 32 + 5] = 8'd0;
        mem[16'h3000 + 5 * 32 + 5] = 8'd7;
        run_px(205, 105, 1, 0);

        // No layers enabled, then an enabled layer that misses
        clear_objs();
        run_px(50, 50, 1, 0);
        obj_en[1] = 1'b1; obj_x[1] = 10'd400; obj_y[1] = 10'd400;
        run_px(50, 50, 1, 0);

        // Single covering layer that is transparent
        clear_objs();
        obj_en[4] = 1'b1; obj_x[4] = 10'd10; obj_y[4] = 10'd10;
        mem[16'h4000 + 3 * 16 + 2] = 8'd0;
        run_px(12, 13, 1, 0);

        // Horizontal edges, including one past the 10-bit range
        clear_objs();
        obj_en[2] = 1'b1; obj_x[2] = 10'd630; obj_y[2] = 10'd0;
        mem[16'h2000 + 9] = 8'd9;
        run_px(639, 0, 1, 0);
        run_px(662, 0, 1, 0);
        run_px(661, 0, 1, 0);
        clear_objs();
        obj_en[5] = 1'b1; obj_x[5] = 10'd1000; obj_y[5] = 10'd0;
        mem[16'h5000 + 23] = 8'd3;
        run_px(1023, 0, 2, 0);

        // Backpressure: hold the result for 5 cycles, then back-to-back pixel
        clear_objs();
        obj_en[6] = 1'b1; obj_x[6] = 10'd20; obj_y[6] = 10'd20;
        run_px(40, 40, 1, 5);
        run_px(41, 40, 1, 0);

        // Reset while waiting for SRAM data; the late response must be ignored
        clear_objs();
        obj_en[1] = 1'b1; obj_x[1] = 10'd300; obj_y[1] = 10'd200;
        px_valid = 1'b1; px_x = 10'd305; px_y = 10'd205; sram_lat = 6;
        @(negedge clk);
        px_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_wait_px_ready", {31'd0, px_ready}, 32'd1);
        chk("rst_wait_valid", {31'd0, valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (valid) saw_valid = 1'b1;
        end
        chk("late_rvalid_ignored", {31'd0, saw_valid}, 32'd0);
        chk("post_rst_px_ready", {31'd0, px_ready}, 32'd1);
        run_px(305, 205, 1, 0);

        // Randomized scenes
        for (int t = 0; t < 40; t++) begin
            x = $urandom_range(0, 1023);
            y = $urandom_range(0, 1023);
            for (int k = 0; k < 8; k++) begin
                obj_en[k] = ($urandom_range(0, 4) < 3);
                obj_x[k]  = 10'((x > 70) ? x - $urandom_range(0, 70) : $urandom_range(0, x));
                obj_y[k]  = 10'((y > 70) ? y - $urandom_range(0, 70) : $urandom_range(0, y));
            end
            run_px(x, y, $urandom_range(1, 3), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
